// File: rtl/dl_pipe_skid.sv
// Valid/ready stage with a 2-entry skid buffer; registered in_rdy/out_vld/out_data.
// Optional stall counter on stall_cnt when DL_SKID_STALL_CNT_EN is defined.
module dl_pipe_skid #(
  parameter int                  NUM_BITS = 32,
  parameter logic [NUM_BITS-1:0] RST_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [NUM_BITS-1:0] out_data
`ifdef DL_SKID_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  // Encoding is {main valid, skid valid}
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_BUSY  = 2'b10,
    S_FULL  = 2'b11
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_BITS-1:0] r_out_data;
  logic [NUM_BITS-1:0] r_skid_data;
  logic                w_ld_main;
  logic                w_ld_skid;
  logic                w_sel_skid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_main   = 1'b0;
    w_ld_skid   = 1'b0;
    w_sel_skid  = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (in_vld) begin
            w_ld_main   = 1'b1;
            w_state_nxt = S_BUSY;
          end
        end
        S_BUSY: begin
          if (in_vld && out_rdy) begin
            w_ld_main = 1'b1;
          end else if (in_vld) begin
            w_ld_skid   = 1'b1;
            w_state_nxt = S_FULL;
          end else if (out_rdy) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_rdy) begin
            w_ld_main   = 1'b1;
            w_sel_skid  = 1'b1;
            w_state_nxt = S_BUSY;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= RST_VAL;
      r_skid_data <= RST_VAL;
    end else begin
      if (w_ld_main) begin
        r_out_data <= w_sel_skid ? r_skid_data : in_data;
      end
      if (w_ld_skid) begin
        r_skid_data <= in_data;
      end
    end
  end

  assign out_vld  = r_state[1];
  assign in_rdy   = ~r_state[0];
  assign out_data = r_out_data;

`ifdef DL_SKID_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (out_vld && !out_rdy && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dl_pipe_skid.sv
// Directed self-checking bench for dl_pipe_skid.
// Counter scenario is exercised only when DL_SKID_STALL_CNT_EN is defined.
module tb_dl_pipe_skid;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_vld;
  logic        in_rdy;
  logic [31:0] in_data;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] out_data;
`ifdef DL_SKID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks;
  int errors;

  dl_pipe_skid #(
    .NUM_BITS(32),
    .RST_VAL (32'h0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_data (in_data),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_data(out_data)
`ifdef DL_SKID_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, settle 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush   = 1'b0;
    in_vld  = 1'b0;
    in_data = 32'h0;
    out_rdy = 1'b0;
  endtask

  task automatic fill_full(input logic [31:0] a, input logic [31:0] b);
    in_vld = 1'b1; in_data = a; out_rdy = 1'b0;
    tick();
    in_data = b;
    tick();
    in_vld = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_init: vld=%b rdy=%b data=%h want 0 1 0",
               out_vld, in_rdy, out_data);
    end
  endtask

  task automatic test_streaming();
    idle();
    out_rdy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_vld = 1'b1; in_data = i;
      tick();
      checks++;
      if (out_vld !== 1'b1 || out_data !== i || in_rdy !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: vld=%b data=%h rdy=%b want 1 %h 1",
                 i, out_vld, out_data, in_rdy, i);
      end
    end
    in_vld = 1'b0;
    tick();
    checks++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL stream_end: vld=%b rdy=%b want 0 1", out_vld, in_rdy);
    end
  endtask

  task automatic test_backpressure();
    idle();
    in_vld = 1'b1; in_data = 32'hA;
    tick();
    checks++;
    if (out_vld !== 1'b1 || out_data !== 32'hA || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL bp_busy: vld=%b data=%h rdy=%b want 1 a 1",
               out_vld, out_data, in_rdy);
    end
    in_data = 32'hB;
    tick();
    checks++;
    if (out_vld !== 1'b1 || out_data !== 32'hA || in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: vld=%b data=%h rdy=%b want 1 a 0",
               out_vld, out_data, in_rdy);
    end
    // upstream holds a new word while not ready; must be ignored
    in_data = 32'hD;
    tick();
    checks++;
    if (out_vld !== 1'b1 || out_data !== 32'hA || in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: vld=%b data=%h rdy=%b want 1 a 0",
               out_vld, out_data, in_rdy);
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    tick();
    checks++;
    if (out_vld !== 1'b1 || out_data !== 32'hB || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: vld=%b data=%h rdy=%b want 1 b 1",
               out_vld, out_data, in_rdy);
    end
    tick();
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: vld=%b want 0", out_vld);
    end
  endtask

  task automatic test_drain();
    idle();
    fill_full(32'hA, 32'hB);
    out_rdy = 1'b1;
    checks++;
    if (out_vld !== 1'b1 || out_data !== 32'hA) begin
      errors++;
      $display("FAIL drain_0: vld=%b data=%h want 1 a", out_vld, out_data);
    end
    tick();
    checks++;
    if (out_vld !== 1'b1 || out_data !== 32'hB) begin
      errors++;
      $display("FAIL drain_1: vld=%b data=%h want 1 b", out_vld, out_data);
    end
    tick();
    checks++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1 || out_data !== 32'hB) begin
      errors++;
      $display("FAIL drain_2: vld=%b rdy=%b data=%h want 0 1 b",
               out_vld, in_rdy, out_data);
    end
  endtask

  task automatic test_flush();
    idle();
    fill_full(32'h11, 32'h22);
    flush = 1'b1; in_vld = 1'b1; in_data = 32'hC;
    tick();
    flush = 1'b0; in_vld = 1'b0;
    checks++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1 || out_data !== 32'h11) begin
      errors++;
      $display("FAIL flush: vld=%b rdy=%b data=%h want 0 1 11",
               out_vld, in_rdy, out_data);
    end
    out_rdy = 1'b1;
    tick();
    checks++;
    if (out_vld !== 1'b0 || out_data === 32'hC) begin
      errors++;
      $display("FAIL flush_after: vld=%b data=%h want 0 not c",
               out_vld, out_data);
    end
    in_vld = 1'b1; in_data = 32'h33;
    tick();
    in_vld = 1'b0;
    checks++;
    if (out_vld !== 1'b1 || out_data !== 32'h33) begin
      errors++;
      $display("FAIL flush_resume: vld=%b data=%h want 1 33",
               out_vld, out_data);
    end
    tick();
  endtask

  task automatic test_async_reset();
    idle();
    fill_full(32'h55, 32'h66);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: vld=%b rdy=%b data=%h want 0 1 0",
               out_vld, in_rdy, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: vld=%b rdy=%b want 0 1", out_vld, in_rdy);
    end
  endtask

`ifdef DL_SKID_STALL_CNT_EN
  task automatic test_counter();
    idle();
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL cnt_reset: cnt=%0d want 0", stall_cnt);
    end
    in_vld = 1'b1; in_data = 32'h77;
    tick();
    in_vld = 1'b0;
    repeat (5) tick();
    checks++;
    if (stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL cnt_5: cnt=%0d want 5", stall_cnt);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    checks++;
    if (stall_cnt !== 16'd6) begin
      errors++;
      $display("FAIL cnt_flush: cnt=%0d want 6", stall_cnt);
    end
    in_vld = 1'b1; in_data = 32'h78;
    tick();
    in_vld = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_sat: cnt=%h want ffff", stall_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL cnt_clear: cnt=%0d want 0", stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    #1;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_streaming();
    test_backpressure();
    test_drain();
    test_flush();
    test_async_reset();
`ifdef DL_SKID_STALL_CNT_EN
    test_counter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dl_pipe_skid.md
Name: dl_pipe_skid

Overview:
- Valid/ready pipeline stage with a 2-entry skid buffer.
- Sits directly upstream of the plain enable registers in the core pipeline. It converts a backpressured valid/ready stream into registered output data, and out_vld & out_rdy forms the downstream register enable.
- Breaks the combinational ready path: in_rdy is a registered signal.
- Sustains full throughput of 1 transfer per cycle.

Parameters:
- NUM_BITS, 32, payload width in bits.
- RST_VAL, 0, reset value of out_data and of the internal skid data register.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline flush; clears all valid entries.
- in_vld  input  1  upstream data valid.
- in_rdy  output  1  upstream ready; registered.
- in_data  input  NUM_BITS  upstream payload.
- out_vld  output  1  downstream data valid; registered.
- out_rdy  input  1  downstream ready.
- out_data  output  NUM_BITS  downstream payload; registered.
- stall_cnt  output  16  stall counter. Present only when DL_SKID_STALL_CNT_EN is defined.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-transfer):
  - State is EMPTY.
  - out_vld=0, in_rdy=1.
  - out_data=RST_VAL, skid data=RST_VAL.
  - Release is synchronous to clk.
- Transfers:
  - Input accept = in_vld & in_rdy.
  - Output transfer = out_vld & out_rdy.
  - Both are sampled at the rising edge.
- States are encoded from the 2 valid bits, main (out) and skid:
  - EMPTY: out_vld=0, in_rdy=1.
  - BUSY: out_vld=1, in_rdy=1.
  - FULL: out_vld=1, in_rdy=0.
- EMPTY transitions:
  - in_vld: out_data<=in_data, go to BUSY.
  - Otherwise: hold.
- BUSY transitions:
  - in_vld & out_rdy: out_data<=in_data, stay BUSY (streaming).
  - in_vld & !out_rdy: skid<=in_data, go to FULL.
  - !in_vld & out_rdy: go to EMPTY.
  - Otherwise: hold.
- FULL transitions:
  - out_rdy: out_data<=skid, go to BUSY.
  - Otherwise: hold. in_rdy=0, so no accept occurs.
- Latency: data accepted at edge N appears on out_data/out_vld after edge N (1 cycle).
- Ordering is strictly FIFO. No data is lost or duplicated.
- out_data and out_vld stay stable while out_vld=1 and out_rdy=0.
- flush=1 at an edge:
  - Next state is EMPTY and in_rdy=1, regardless of in_vld and out_rdy.
  - An input presented in the same cycle is dropped.
  - Data registers hold their values; only the valids clear.
- Data registers load only on their enable conditions above; otherwise they hold.
- in_vld while in_rdy=0 has no effect; the upstream must hold in_data.

Optional Feature:
- Macro: DL_SKID_STALL_CNT_EN.
- When defined:
  - The stall_cnt port exists.
  - The 16-bit counter increments on each cycle where out_vld=1 & out_rdy=0.
  - It saturates at 16'hFFFF.
  - Reset (async) clears it to 0; flush does not clear it.
- When undefined:
  - No port and no counter logic.
  - All other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-FULL state with out_data=0x55 -> immediately out_vld=0, in_rdy=1, out_data=RST_VAL(0) without waiting for a clk edge.
- Streaming: out_rdy=1, send 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 each 1 cycle later; in_rdy stays 1; zero bubbles.
- Backpressure: BUSY holding 0xA, out_rdy=0, send 0xB -> FULL, in_rdy=0, out_data stays 0xA. Then out_rdy=1 -> 0xA out, next edge out_data=0xB, in_rdy=1.
- Drain: FULL with 0xA/0xB, in_vld=0, out_rdy=1 for 2 cycles -> outputs 0xA then 0xB, then out_vld=0 (EMPTY).
- Flush: FULL, flush=1 with in_vld=1 in_data=0xC -> next cycle out_vld=0, in_rdy=1; 0xC never appears.
- Counter (macro defined): out_vld=1, out_rdy=0 for 5 cycles -> stall_cnt=5. Preload near saturation via a long stall -> holds at 0xFFFF.
